// File: rtl/altusoc_pkg.sv
// Shared constants for the altusoc Wishbone blocks: default bus widths and
// the arbiter state encoding.
package altusoc_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  // state    | meaning
  // ST_IDLE  | no owner, arbitrate between requesting masters
  // ST_BUSY  | owner holds cyc, slave signals muxed from owner
  // ST_ABORT | one-cycle abort after watchdog expiry, err to owner
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

endpackage

// File: rtl/altusoc_wb_watchdog.sv
// Bus access watchdog: counts strobed cycles without a response and flags
// expiry on the cycle the count would pass TIMEOUT-1.
module altusoc_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear has priority over counting; the count holds when not enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire = en & (cnt_q == LAST);

endmodule

// File: rtl/altusoc_wb_arb.sv
// Two-master Wishbone classic arbiter, round-robin on ties, grant held for
// the owner's whole cyc, with a watchdog that aborts unanswered accesses.
module altusoc_wb_arb
  import altusoc_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_m0_adr,
  input  logic [DW-1:0]   i_m0_dat,
  input  logic [DW/8-1:0] i_m0_sel,
  input  logic            i_m0_we,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  output logic [DW-1:0]   o_m0_rdt,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  input  logic [AW-1:0]   i_m1_adr,
  input  logic [DW-1:0]   i_m1_dat,
  input  logic [DW/8-1:0] i_m1_sel,
  input  logic            i_m1_we,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  output logic [DW-1:0]   o_m1_rdt,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic [AW-1:0]   o_s_adr,
  output logic [DW-1:0]   o_s_dat,
  output logic [DW/8-1:0] o_s_sel,
  output logic            o_s_we,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  input  logic [DW-1:0]   i_s_rdt,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  output logic [1:0]      o_grant,
  output logic            o_timeout
);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;

  logic req0, req1;
  logic own_cyc, own_stb;
  logic busy, abort, resp;
  logic wd_clr, wd_en, wd_expire;

  assign req0    = i_m0_cyc & i_m0_stb;
  assign req1    = i_m1_cyc & i_m1_stb;
  assign own_cyc = owner_q ? i_m1_cyc : i_m0_cyc;
  assign own_stb = owner_q ? i_m1_stb : i_m0_stb;
  assign busy    = (state_q == ST_BUSY);
  assign abort   = (state_q == ST_ABORT);
  assign resp    = i_s_ack | i_s_err;

  // Clearing throughout IDLE guarantees a zero count on entry to BUSY.
  assign wd_clr = ~busy | resp;
  assign wd_en  = busy & own_cyc & own_stb & ~resp;

  altusoc_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Next-state: arbitrate in IDLE, hold grant in BUSY, single-cycle ABORT.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          owner_d = (req0 & req1) ? ~last_q : req1;
          last_d  = owner_d;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (wd_expire)
          state_d = ST_ABORT;
        else if (!own_cyc)
          state_d = ST_IDLE;
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, owner and round-robin history registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign o_s_adr = owner_q ? i_m1_adr : i_m0_adr;
  assign o_s_dat = owner_q ? i_m1_dat : i_m0_dat;
  assign o_s_sel = owner_q ? i_m1_sel : i_m0_sel;
  assign o_s_we  = owner_q ? i_m1_we  : i_m0_we;
  assign o_s_cyc = busy & own_cyc;
  assign o_s_stb = busy & own_stb;

  assign o_m0_rdt = i_s_rdt;
  assign o_m1_rdt = i_s_rdt;

  // Slave responses reach only the owner and only in BUSY; late ones in
  // ABORT are dropped in favour of the timeout error.
  assign o_m0_ack = busy & i_s_ack & ~owner_q;
  assign o_m1_ack = busy & i_s_ack &  owner_q;
  assign o_m0_err = ~owner_q & ((busy & i_s_err) | abort);
  assign o_m1_err =  owner_q & ((busy & i_s_err) | abort);

  assign o_grant   = (busy | abort) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_timeout = abort;

endmodule

// File: doc/altusoc_wb_arb.md
# altusoc_wb_arb

Two-master Wishbone classic arbiter with a bus-timeout watchdog, placed between the IO Wishbone masters and the shared `io` slave port of the Wishbone interconnect.
- Master 0 is the axi2wb bridge output; master 1 is a secondary master, such as a debug or DMA engine.
- The block grants one master at a time with round-robin fairness, holds the grant for the owner's whole `cyc` cycle, and aborts any access the slave does not answer within `TIMEOUT` cycles, returning `err` to that master.

## Interface
Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width; `sel` width is `DW/8`.
- `TIMEOUT`, default 255: maximum number of cycles a strobed access may wait for `ack`/`err`. Must be ≥ 2.

Ports. Clock is `i_clk`; reset is `i_rst`, synchronous, active-high.
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: synchronous active-high reset.
- `i_m0_adr`, `i_m1_adr`, in, AW: master addresses.
- `i_m0_dat`, `i_m1_dat`, in, DW: master write data.
- `i_m0_sel`, `i_m1_sel`, in, DW/8: byte selects.
- `i_m0_we`, `i_m1_we`, in, 1: write enables.
- `i_m0_cyc`, `i_m1_cyc`, in, 1: bus cycle requests.
- `i_m0_stb`, `i_m1_stb`, in, 1: strobes.
- `o_m0_rdt`, `o_m1_rdt`, out, DW: read data, driven directly from `i_s_rdt`.
- `o_m0_ack`, `o_m1_ack`, out, 1: acknowledges.
- `o_m0_err`, `o_m1_err`, out, 1: errors (slave error or timeout).
- `o_s_adr`, `o_s_dat`, `o_s_sel`, `o_s_we`, out, AW/DW/DW/8/1: signals of the granted master, passed to the slave.
- `o_s_cyc`, `o_s_stb`, out, 1: slave cycle and strobe, gated by grant.
- `i_s_rdt`, in, DW: slave read data.
- `i_s_ack`, `i_s_err`, in, 1: slave responses.
- `o_grant`, out, 2: one-hot owner; `00` when idle.
- `o_timeout`, out, 1: one-cycle pulse when an access is aborted.

## Operation
The state register takes one of three values: IDLE, BUSY, ABORT. The `owner` register is 1 bit; `last` is 1 bit.

IDLE:
- `o_s_cyc` = `o_s_stb` = 0.
- A request is `cyc & stb`.
- Only one master requesting: that master becomes `owner`, and the next state is BUSY.
- Both requesting: grant goes to `~last`.
- On a grant, `last` ← the granted master.

BUSY:
- Slave outputs are muxed from `owner`; `o_s_cyc`/`o_s_stb` follow the owner's `cyc`/`stb`.
- `o_mX_ack` = `i_s_ack & (owner==X)`; `o_mX_err` = `i_s_err & (owner==X)`.
- The non-owner sees `ack` = `err` = 0.
- Owner drops `cyc` → IDLE next cycle. The non-owner is arbitrated in that IDLE cycle.
- The grant is never revoked while the owner holds `cyc`, except on timeout.

Watchdog:
- Counter width is `$clog2(TIMEOUT+1)`.
- Cleared on entry to BUSY and on any cycle with `i_s_ack | i_s_err`.
- Increments on each BUSY cycle with owner `stb` high and no response.
- Holds its value while `stb` is low.
- If counter == `TIMEOUT-1` and no response arrives that cycle, the next state is ABORT.

ABORT (exactly one cycle):
- `o_s_cyc` = `o_s_stb` = 0.
- `o_mX_err` = 1 to the owner only; `o_timeout` = 1.
- A late `i_s_ack`/`i_s_err` from the slave is ignored and not forwarded.
- Next state is IDLE, with `last` unchanged.

Boundary conditions:
- A response in the same cycle the counter reaches `TIMEOUT-1` wins: the response is forwarded and there is no abort.
- A master raising `cyc` without `stb` is not a request.
- Reset is synchronous. Reset values:
  - state = IDLE, `owner` = 0, `last` = 1 (so m0 wins the first tie), counter = 0.
  - `o_grant` = 00, `o_timeout` = 0.
  - All `o_s_cyc`/`o_s_stb`/`ack`/`err` outputs = 0, since they are gated by the registered state.
- An abandoned slave access after reset mid-transaction is the slave's responsibility.

## Timing
- Arbitration latency: request in cycle N → `o_s_stb` in cycle N+1. This is the only added latency.
- Slave-to-master `ack`/`err`/`rdt` is combinational, with zero added cycles; pipelined back-to-back accesses by the owner run at full rate.
- Handover: owner `cyc` low in cycle N → IDLE in N+1 → other master's `stb` on the slave in N+2.
- Timeout: an un-answered strobe first seen in BUSY cycle S gets ABORT/`err` in cycle S+TIMEOUT.

## Structure
- State encoding localparams (IDLE/BUSY/ABORT) belong in the shared `altusoc_pkg` include, alongside the Wishbone width constants.
- Natural sub-module: `altusoc_wb_watchdog`.
  - Inputs: `i_clk`, `i_rst`, `clr`, `en`.
  - Output: `expire`, with `TIMEOUT` as a parameter.
  - Reused later by other bus bridges.
- The rest is one state process plus combinational muxes.

## Test plan
1. Reset, then m0 read request with slave ack 3 cycles later → `o_grant`=01 one cycle after request, `o_m0_ack`=1 with `o_m0_rdt`=`i_s_rdt`; `o_m1_ack` stays 0.
2. m0 and m1 request in the same cycle, repeated 4 times with release → grants alternate m0, m1, m0, m1.
3. m0 holds `cyc` for 3 back-to-back pipelined accesses while m1 requests → m1 is not granted until 2 cycles after m0 drops `cyc`.
4. `TIMEOUT`=8, slave never acks → m0 `err` and `o_timeout` both 1 exactly 8 cycles after first strobe, `o_s_cyc`=0 that cycle, IDLE after.
5. `TIMEOUT`=8, slave ack on the 8th waiting cycle → ack forwarded, no `err`, no `o_timeout`.
6. `i_rst` asserted mid-BUSY → next cycle `o_s_cyc`=0, `o_grant`=00; simultaneous request afterwards grants m0.
